// File: rtl/lsu_pkg.sv
// Shared types and constants for the MEM-stage load/store unit.
package lsu_pkg;

  localparam int unsigned DataW = 32;
  localparam int unsigned BeW   = DataW / 8;

  typedef enum logic [1:0] {StIdle, StReq, StResp, StDone} lsu_state_e;

  typedef enum logic [1:0] {SzByte, SzHalf, SzWord} lsu_size_e;

  localparam logic [2:0] F3Lb  = 3'b000;
  localparam logic [2:0] F3Lh  = 3'b001;
  localparam logic [2:0] F3Lw  = 3'b010;
  localparam logic [2:0] F3Lbu = 3'b100;
  localparam logic [2:0] F3Lhu = 3'b101;

  // funct3[2] only selects zero-extension; undefined encodings fall back to word.
  function automatic lsu_size_e f3_size(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   f3_size = SzByte;
      2'b01:   f3_size = SzHalf;
      default: f3_size = SzWord;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lsu_align.sv
// Combinational lane logic: store replication and byte enables, load shift and extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]       funct3,
  input  logic [1:0]       addr_lo,
  input  logic             we,
  input  logic [DataW-1:0] store_data,
  input  logic [DataW-1:0] rdata,
  output logic [BeW-1:0]   be,
  output logic [DataW-1:0] wdata,
  output logic [DataW-1:0] load_data
);

  lsu_size_e        size;
  logic [DataW-1:0] byte_sh;
  logic [DataW-1:0] half_sh;
  logic             ext_b;
  logic             ext_h;

  always_comb begin
    size    = f3_size(funct3);
    byte_sh = rdata >> {addr_lo, 3'b000};
    half_sh = rdata >> {addr_lo[1], 4'b0000};
    ext_b   = ~funct3[2] & byte_sh[7];
    ext_h   = ~funct3[2] & half_sh[15];
  end

  always_comb begin
    be        = '1;
    wdata     = store_data;
    load_data = rdata;
    case (size)
      SzByte: begin
        if (we) be = 4'b0001 << addr_lo;
        wdata     = {4{store_data[7:0]}};
        load_data = {{24{ext_b}}, byte_sh[7:0]};
      end
      SzHalf: begin
        if (we) be = 4'b0011 << {addr_lo[1], 1'b0};
        wdata     = {2{store_data[15:0]}};
        load_data = {{16{ext_h}}, half_sh[15:0]};
      end
      default: begin
        be        = '1;
        wdata     = store_data;
        load_data = rdata;
      end
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// MEM-stage load/store unit: valid/grant/response bus FSM with registered load result.
// Optional misaligned-access trap enabled by defining LSU_MISALIGN_TRAP_EN.
module dmem_lsu
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_req_m,
  input  logic              mem_we_m,
  input  logic [2:0]        mem_funct3_m,
  input  logic [ADDR_W-1:0] execute_out_m,
  input  logic [DataW-1:0]  store_data_m,
  output logic [DataW-1:0]  dmem_readdata_m,
  output logic              lsu_stall_m,
  output logic              misalign_m,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DataW-1:0]  dmem_wdata,
  output logic [BeW-1:0]    dmem_be,
  input  logic              dmem_gnt,
  input  logic              dmem_rvalid,
  input  logic [DataW-1:0]  dmem_rdata
);

  lsu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [DataW-1:0]  sdata_q;
  logic [DataW-1:0]  rd_q;

  logic              issue;
  logic              use_live;
  logic [ADDR_W-1:0] a_addr;
  logic              a_we;
  logic [2:0]        a_f3;
  logic [DataW-1:0]  a_sdata;
  logic [BeW-1:0]    al_be;
  logic [DataW-1:0]  al_wdata;
  logic [DataW-1:0]  al_load;

`ifdef LSU_MISALIGN_TRAP_EN
  lsu_size_e live_size;
  always_comb begin
    live_size  = f3_size(mem_funct3_m);
    misalign_m = (state_q == StIdle) && mem_req_m &&
                 (((live_size == SzHalf) && execute_out_m[0]) ||
                  ((live_size == SzWord) && (execute_out_m[1:0] != 2'b00)));
  end
`else
  assign misalign_m = 1'b0;
`endif

  assign issue    = (state_q == StIdle) && mem_req_m && !misalign_m;
  // In IDLE the request goes out in the same cycle, so the bus sees the live inputs.
  assign use_live = (state_q == StIdle);

  always_comb begin
    a_addr  = use_live ? execute_out_m : addr_q;
    a_we    = use_live ? mem_we_m      : we_q;
    a_f3    = use_live ? mem_funct3_m  : f3_q;
    a_sdata = use_live ? store_data_m  : sdata_q;
  end

  lsu_align u_align (
    .funct3     (a_f3),
    .addr_lo    (a_addr[1:0]),
    .we         (a_we),
    .store_data (a_sdata),
    .rdata      (dmem_rdata),
    .be         (al_be),
    .wdata      (al_wdata),
    .load_data  (al_load)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (issue) begin
          if (dmem_gnt) state_d = mem_we_m ? StDone : StResp;
          else          state_d = StReq;
        end
      end
      StReq: begin
        if (dmem_gnt) state_d = we_q ? StDone : StResp;
      end
      StResp: begin
        if (dmem_rvalid) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    dmem_req    = issue || (state_q == StReq);
    lsu_stall_m = issue || (state_q == StReq) || (state_q == StResp);
    dmem_we     = 1'b0;
    dmem_addr   = '0;
    dmem_wdata  = '0;
    dmem_be     = '0;
    if (dmem_req) begin
      dmem_we    = a_we;
      dmem_addr  = {a_addr[ADDR_W-1:2], 2'b00};
      dmem_wdata = al_wdata;
      dmem_be    = al_be;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q  <= '0;
      we_q    <= 1'b0;
      f3_q    <= '0;
      sdata_q <= '0;
      rd_q    <= '0;
    end else begin
      if (issue) begin
        addr_q  <= execute_out_m;
        we_q    <= mem_we_m;
        f3_q    <= mem_funct3_m;
        sdata_q <= store_data_m;
      end
      if ((state_q == StResp) && dmem_rvalid) begin
        rd_q <= al_load;
      end
    end
  end

  assign dmem_readdata_m = rd_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Self-checking bench for dmem_lsu: scripted bus responder with a load-result scoreboard.
module tb_dmem_lsu;

  logic        clk;
  logic        reset;
  logic        mem_req_m;
  logic        mem_we_m;
  logic [2:0]  mem_funct3_m;
  logic [31:0] execute_out_m;
  logic [31:0] store_data_m;
  logic [31:0] dmem_readdata_m;
  logic        lsu_stall_m;
  logic        misalign_m;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;

  int          n_checks;
  int          n_fail;
  logic [31:0] last_rd;
  logic [31:0] sb_q[$];

  dmem_lsu #(.ADDR_W(32)) dut (
    .clk             (clk),
    .reset           (reset),
    .mem_req_m       (mem_req_m),
    .mem_we_m        (mem_we_m),
    .mem_funct3_m    (mem_funct3_m),
    .execute_out_m   (execute_out_m),
    .store_data_m    (store_data_m),
    .dmem_readdata_m (dmem_readdata_m),
    .lsu_stall_m     (lsu_stall_m),
    .misalign_m      (misalign_m),
    .dmem_req        (dmem_req),
    .dmem_we         (dmem_we),
    .dmem_addr       (dmem_addr),
    .dmem_wdata      (dmem_wdata),
    .dmem_be         (dmem_be),
    .dmem_gnt        (dmem_gnt),
    .dmem_rvalid     (dmem_rvalid),
    .dmem_rdata      (dmem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Reference extraction written per lane, independent of shift arithmetic.
  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [1:0] a,
                                           input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    case (a)
      2'd0: b = rd[7:0];
      2'd1: b = rd[15:8];
      2'd2: b = rd[23:16];
      default: b = rd[31:24];
    endcase
    h = a[1] ? rd[31:16] : rd[15:0];
    case (f3)
      3'b000:  exp_load = {{24{b[7]}}, b};
      3'b100:  exp_load = {24'h0, b};
      3'b001:  exp_load = {{16{h[15]}}, h};
      3'b101:  exp_load = {16'h0, h};
      default: exp_load = rd;
    endcase
  endfunction

  // Called at a negedge; returns at the negedge following DONE with mem_req_m still high.
  task automatic run_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] sdata, input logic [31:0] rdata,
                        input int gnt_dly, input int rv_dly,
                        input logic [3:0] exp_be, input logic [31:0] exp_wdata);
    logic [31:0] exp_rd;
    if (we) exp_rd = last_rd;
    else    exp_rd = exp_load(f3, addr[1:0], rdata);
    sb_q.push_back(exp_rd);
    last_rd = exp_rd;

    mem_req_m     = 1'b1;
    mem_we_m      = we;
    mem_funct3_m  = f3;
    execute_out_m = addr;
    store_data_m  = sdata;

    for (int i = 0; i <= gnt_dly; i++) begin
      dmem_gnt    = (i == gnt_dly);
      dmem_rvalid = 1'b1;
      dmem_rdata  = 32'hA5A5_A5A5;
      #1;
      check_eq("req", dmem_req, 1);
      check_eq("stall_req", lsu_stall_m, 1);
      check_eq("bus_we", dmem_we, we);
      check_eq("bus_addr", dmem_addr, addr & 32'hFFFF_FFFC);
      check_eq("bus_be", dmem_be, we ? exp_be : 4'hF);
      if (we) check_eq("bus_wdata", dmem_wdata, exp_wdata);
      @(negedge clk);
      dmem_gnt    = 1'b0;
      dmem_rvalid = 1'b0;
      // Pipeline inputs change under stall; the latched copy must be used.
      execute_out_m = 32'hFFFF_FFFF;
      store_data_m  = 32'h5A5A_5A5A;
      mem_funct3_m  = 3'b000;
      mem_we_m      = ~we;
    end

    if (!we) begin
      for (int j = 0; j <= rv_dly; j++) begin
        dmem_rvalid = (j == rv_dly);
        dmem_rdata  = (j == rv_dly) ? rdata : 32'h1234_5678;
        dmem_gnt    = 1'b1;
        #1;
        check_eq("stall_resp", lsu_stall_m, 1);
        check_eq("req_resp", dmem_req, 0);
        @(negedge clk);
        dmem_rvalid = 1'b0;
        dmem_gnt    = 1'b0;
      end
    end

    #1;
    check_eq("stall_done", lsu_stall_m, 0);
    check_eq("req_done", dmem_req, 0);
    if (sb_q.size() == 0) begin
      check_eq("sb_empty", 1, 0);
    end else begin
      check_eq("readdata", dmem_readdata_m, sb_q.pop_front());
    end
    @(negedge clk);
  endtask

  task automatic idle_cycle();
    mem_req_m   = 1'b0;
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b0;
    #1;
    check_eq("idle_stall", lsu_stall_m, 0);
    check_eq("idle_req", dmem_req, 0);
    @(negedge clk);
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    last_rd       = 32'h0;
    reset         = 1'b1;
    mem_req_m     = 1'b0;
    mem_we_m      = 1'b0;
    mem_funct3_m  = 3'b000;
    execute_out_m = 32'h0;
    store_data_m  = 32'h0;
    dmem_gnt      = 1'b0;
    dmem_rvalid   = 1'b0;
    dmem_rdata    = 32'h0;
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_readdata", dmem_readdata_m, 0);
    check_eq("rst_stall", lsu_stall_m, 0);
    check_eq("rst_misalign", misalign_m, 0);
    check_eq("rst_req", dmem_req, 0);
    check_eq("rst_we", dmem_we, 0);
    check_eq("rst_addr", dmem_addr, 0);
    check_eq("rst_wdata", dmem_wdata, 0);
    check_eq("rst_be", dmem_be, 0);
    @(negedge clk);
    reset = 1'b0;
    idle_cycle();

    run_op(0, 3'b010, 32'h100, 0, 32'hDEAD_BEEF, 0, 0, 4'h0, 0);
    run_op(0, 3'b000, 32'h103, 0, 32'h8011_2233, 0, 0, 4'h0, 0);
    run_op(0, 3'b100, 32'h103, 0, 32'h8011_2233, 0, 0, 4'h0, 0);
    run_op(0, 3'b001, 32'h102, 0, 32'h8011_2233, 0, 0, 4'h0, 0);
    idle_cycle();
    run_op(1, 3'b001, 32'h202, 32'h0000_ABCD, 0, 3, 0, 4'b1100, 32'hABCD_ABCD);
    run_op(1, 3'b000, 32'h201, 32'h1234_5678, 0, 1, 0, 4'b0010, 32'h7878_7878);
    run_op(1, 3'b010, 32'h300, 32'hCAFE_F00D, 0, 0, 0, 4'b1111, 32'hCAFE_F00D);
    run_op(1, 3'b001, 32'h200, 32'h0000_1357, 0, 0, 0, 4'b0011, 32'h1357_1357);
    run_op(0, 3'b101, 32'h102, 0, 32'h8011_2233, 1, 2, 4'h0, 0);
    run_op(0, 3'b011, 32'h104, 0, 32'h0BAD_F00D, 0, 1, 4'h0, 0);
    idle_cycle();

    for (int k = 0; k < 4; k++) begin
      run_op(0, 3'b000, 32'h500 + k, 0, 32'hF0E1_7F80, 0, 0, 4'h0, 0);
      run_op(0, 3'b100, 32'h500 + k, 0, 32'hF0E1_7F80, k % 2, 0, 4'h0, 0);
    end
    run_op(0, 3'b010, 32'h600, 0, 32'h1111_2222, 0, 0, 4'h0, 0);
    run_op(0, 3'b010, 32'h604, 0, 32'h3333_4444, 0, 0, 4'h0, 0);
    idle_cycle();

`ifdef LSU_MISALIGN_TRAP_EN
    mem_req_m     = 1'b1;
    mem_we_m      = 1'b0;
    mem_funct3_m  = 3'b010;
    execute_out_m = 32'h101;
    dmem_gnt      = 1'b1;
    #1;
    check_eq("mis_flag", misalign_m, 1);
    check_eq("mis_req", dmem_req, 0);
    check_eq("mis_stall", lsu_stall_m, 0);
    @(negedge clk);
    mem_funct3_m  = 3'b001;
    execute_out_m = 32'h203;
    #1;
    check_eq("mis_h_flag", misalign_m, 1);
    check_eq("mis_h_stall", lsu_stall_m, 0);
    check_eq("mis_readdata", dmem_readdata_m, last_rd);
    @(negedge clk);
    idle_cycle();
`else
    run_op(0, 3'b010, 32'h101, 0, 32'h1122_3344, 0, 0, 4'h0, 0);
    idle_cycle();
    check_eq("no_mis_flag", misalign_m, 0);
`endif

    // Reset while waiting for the response; the late rvalid must be dropped.
    mem_req_m     = 1'b1;
    mem_we_m      = 1'b0;
    mem_funct3_m  = 3'b010;
    execute_out_m = 32'h400;
    dmem_gnt      = 1'b1;
    #1;
    check_eq("rr_req", dmem_req, 1);
    @(negedge clk);
    dmem_gnt  = 1'b0;
    mem_req_m = 1'b0;
    #1;
    check_eq("rr_stall_resp", lsu_stall_m, 1);
    reset = 1'b1;
    @(negedge clk);
    reset       = 1'b0;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h9999_9999;
    #1;
    check_eq("rr_stall", lsu_stall_m, 0);
    check_eq("rr_req_low", dmem_req, 0);
    @(negedge clk);
    dmem_rvalid = 1'b0;
    #1;
    check_eq("rr_stall2", lsu_stall_m, 0);
    check_eq("rr_readdata", dmem_readdata_m, 0);
    last_rd = 32'h0;
    @(negedge clk);
    run_op(0, 3'b001, 32'h402, 0, 32'h7FFF_0001, 0, 0, 4'h0, 0);
    idle_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
